// File: rtl/m6502_bridge_pkg.sv
// Shared types and constants for the 6502 CPU-bus to valid/ready bridge.
package m6502_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    REQ   = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wfifo_entry_t;

  localparam logic [7:0] DIN_IDLE = 8'hFF;

endpackage

// File: rtl/m6502_wfifo.sv
// Synchronous write-buffer FIFO. Pushes while full and pops while empty are ignored;
// DEPTH must be a power of two so the pointers wrap naturally.
module m6502_wfifo
  import m6502_bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  wfifo_entry_t  din_i,
  output wfifo_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  wfifo_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // Status flags, qualified push/pop and head-of-queue view.
  always_comb begin
    full_o  = (count_q == CNT_FULL);
    empty_o = (count_q == {CW{1'b0}});
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    head_o  = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/m6502_bus_bridge.sv
// Bridges 6502 bus cycles onto a valid/ready request stream with a posted-write FIFO.
// Define M6502_BRIDGE_TRACE_EN to add the cyc_cnt/fetch_cnt trace counters.
module m6502_bus_bridge
  import m6502_bridge_pkg::*;
#(
  parameter int         WFIFO_DEPTH = 4,
  parameter logic [7:0] RESET_DIN   = DIN_IDLE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ph2,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rwn,
  input  logic        cpu_sync,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [15:0] req_addr,
  output logic [7:0]  req_wdata,
  output logic        req_fetch,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_rdata,
`ifdef M6502_BRIDGE_TRACE_EN
  output logic [31:0] cyc_cnt,
  output logic [31:0] fetch_cnt,
`endif
  output logic        ovf
);

  localparam int            CW       = $clog2(WFIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] BP_LEVEL = CW'(WFIFO_DEPTH - 1);

  state_t        state_q;
  logic          ph2_q;
  logic [15:0]   cap_addr_q;
  logic          cap_rwn_q;
  logic [15:0]   rd_addr_q;
  logic          rd_sync_q;
  logic          hold_valid_q;
  logic [15:0]   hold_addr_q;
  logic [7:0]    hold_data_q;
  logic [7:0]    cpu_din_q;
  logic          cpu_rdy_q;
  logic          req_valid_q;
  logic          req_we_q;
  logic [15:0]   req_addr_q;
  logic [7:0]    req_wdata_q;
  logic          req_fetch_q;
  logic          ovf_q;

  logic          rise;
  logic          fall;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          rd_hit;
  logic          rd_miss;
  logic          backpressure;
  logic [CW-1:0] fifo_count_d;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  wfifo_entry_t  fifo_din;
  wfifo_entry_t  fifo_head;

  m6502_wfifo #(
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // PH2 edge decode, FIFO traffic and read hit/miss classification.
  always_comb begin
    rise     = ph2 & ~ph2_q;
    fall     = ~ph2 & ph2_q;
    push     = fall & ~cap_rwn_q;
    push_ok  = push & ~fifo_full;
    pop      = req_valid_q & req_ready & req_we_q;
    fifo_din = '{addr: cap_addr_q, data: cpu_dout};
    if (push_ok && !pop) begin
      fifo_count_d = fifo_count + CNT_ONE;
    end else if (pop && !push_ok) begin
      fifo_count_d = fifo_count - CNT_ONE;
    end else begin
      fifo_count_d = fifo_count;
    end
    // Stall early enough that only one more in-flight write can still land.
    backpressure = (fifo_count_d >= BP_LEVEL);
    rd_hit  = (state_q == IDLE) & rise & cpu_rwn & hold_valid_q & (hold_addr_q == cpu_addr);
    rd_miss = (state_q == IDLE) & rise & cpu_rwn & ~rd_hit;
  end

  // Bridge state machine with registered CPU-side and request-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ph2_q        <= 1'b0;
      cap_addr_q   <= 16'h0000;
      cap_rwn_q    <= 1'b1;
      rd_addr_q    <= 16'h0000;
      rd_sync_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= 16'h0000;
      hold_data_q  <= 8'h00;
      cpu_din_q    <= RESET_DIN;
      cpu_rdy_q    <= 1'b1;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= 16'h0000;
      req_wdata_q  <= 8'h00;
      req_fetch_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      ph2_q <= ph2;
      if (rise) begin
        cap_addr_q <= cpu_addr;
        cap_rwn_q  <= cpu_rwn;
      end
      if (push && fifo_full) begin
        ovf_q <= 1'b1;
      end

      // Posted writes drain from the FIFO head; a popped slot idles one clk before reloading.
      if ((state_q == IDLE) || (state_q == DRAIN)) begin
        if (pop) begin
          req_valid_q <= 1'b0;
          req_we_q    <= 1'b0;
        end else if (!req_valid_q && !fifo_empty) begin
          req_valid_q <= 1'b1;
          req_we_q    <= 1'b1;
          req_addr_q  <= fifo_head.addr;
          req_wdata_q <= fifo_head.data;
          req_fetch_q <= 1'b0;
        end
      end

      case (state_q)
        IDLE: begin
          cpu_rdy_q <= ~backpressure;
          if (rd_hit) begin
            cpu_din_q    <= hold_data_q;
            hold_valid_q <= 1'b0;
          end else if (rd_miss) begin
            cpu_din_q    <= RESET_DIN;
            cpu_rdy_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            rd_addr_q    <= cpu_addr;
            rd_sync_q    <= cpu_sync;
            if (fifo_empty) begin
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              req_we_q    <= 1'b0;
              req_addr_q  <= cpu_addr;
              req_wdata_q <= 8'h00;
              req_fetch_q <= cpu_sync;
            end else begin
              state_q <= DRAIN;
            end
          end else if (rise) begin
            cpu_din_q <= RESET_DIN;
          end
        end
        DRAIN: begin
          cpu_rdy_q <= 1'b0;
          if (fifo_empty && !req_valid_q) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
            req_we_q    <= 1'b0;
            req_addr_q  <= rd_addr_q;
            req_wdata_q <= 8'h00;
            req_fetch_q <= rd_sync_q;
          end
        end
        REQ: begin
          cpu_rdy_q <= 1'b0;
          if (req_valid_q && req_ready) begin
            state_q     <= RESP;
            req_valid_q <= 1'b0;
            req_fetch_q <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_valid) begin
            hold_valid_q <= 1'b1;
            hold_addr_q  <= rd_addr_q;
            hold_data_q  <= rsp_rdata;
            cpu_rdy_q    <= ~backpressure;
            state_q      <= IDLE;
          end else begin
            cpu_rdy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          cpu_rdy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef M6502_BRIDGE_TRACE_EN
  logic [31:0] cyc_cnt_q;
  logic [31:0] fetch_cnt_q;

  // Bus-cycle and opcode-fetch counters, both wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q   <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else if (rise) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (cpu_sync && cpu_rdy_q) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign fetch_cnt = fetch_cnt_q;
`endif

  assign cpu_din   = cpu_din_q;
  assign cpu_rdy   = cpu_rdy_q;
  assign req_valid = req_valid_q;
  assign req_we    = req_we_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign req_fetch = req_fetch_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_m6502_bus_bridge.sv
// Directed self-checking bench for m6502_bus_bridge (WFIFO_DEPTH = 4).
module tb_m6502_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ph2;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rwn;
  logic        cpu_sync;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_fetch;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        ovf;
`ifdef M6502_BRIDGE_TRACE_EN
  logic [31:0] cyc_cnt;
  logic [31:0] fetch_cnt;
`endif

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  int          hs_cnt = 0;
  logic        hs_we    [0:15];
  logic [15:0] hs_addr  [0:15];
  logic [7:0]  hs_wdata [0:15];

  m6502_bus_bridge #(
    .WFIFO_DEPTH (4),
    .RESET_DIN   (8'hFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ph2       (ph2),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_rwn   (cpu_rwn),
    .cpu_sync  (cpu_sync),
    .cpu_din   (cpu_din),
    .cpu_rdy   (cpu_rdy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_fetch (req_fetch),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
`ifdef M6502_BRIDGE_TRACE_EN
    .cyc_cnt   (cyc_cnt),
    .fetch_cnt (fetch_cnt),
`endif
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Log every downstream handshake; inputs only change just after posedge.
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready && hs_cnt < 16) begin
      hs_we[hs_cnt]    = req_we;
      hs_addr[hs_cnt]  = req_addr;
      hs_wdata[hs_cnt] = req_wdata;
      hs_cnt           = hs_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic s);
    cpu_addr = a;
    cpu_rwn  = 1'b0;
    cpu_sync = s;
    ph2      = 1'b1;
    step(1);
    cpu_dout = d;
    ph2      = 1'b0;
    step(1);
    cpu_rwn  = 1'b1;
    cpu_sync = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ph2 = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00;
    cpu_rwn = 1'b1; cpu_sync = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_rdata = 8'h00;
    step(3);
    rst = 1'b0;
    step(2);

    // Reset state
    check("rst_din",   {24'd0, cpu_din}, 32'h0000_00FF);
    check("rst_rdy",   {31'd0, cpu_rdy}, 32'd1);
    check("rst_valid", {31'd0, req_valid}, 32'd0);
    check("rst_ovf",   {31'd0, ovf}, 32'd0);
    check("rst_addr",  {16'd0, req_addr}, 32'h0000_0000);

    // Single posted write
    req_ready = 1'b1;
    cpu_write(16'h0200, 8'h5A, 1'b0);
    step(1);
    check("wr_valid", {31'd0, req_valid}, 32'd1);
    check("wr_we",    {31'd0, req_we}, 32'd1);
    check("wr_addr",  {16'd0, req_addr}, 32'h0000_0200);
    check("wr_wdata", {24'd0, req_wdata}, 32'h0000_005A);
    check("wr_fetch", {31'd0, req_fetch}, 32'd0);
    step(3);
    check("wr_drained", {31'd0, req_valid}, 32'd0);
    check("wr_hs_cnt",  hs_cnt, 32'd1);

    // Read miss, response, repeated cycle hits the hold
    cpu_addr = 16'hFFFC; cpu_rwn = 1'b1; cpu_sync = 1'b0; ph2 = 1'b1;
    step(1);
    check("rd_rdy_low", {31'd0, cpu_rdy}, 32'd0);
    check("rd_valid",   {31'd0, req_valid}, 32'd1);
    check("rd_we",      {31'd0, req_we}, 32'd0);
    check("rd_addr",    {16'd0, req_addr}, 32'h0000_FFFC);
    step(2);
    check("rd_wait_rdy", {31'd0, cpu_rdy}, 32'd0);
    check("rd_wait_vld", {31'd0, req_valid}, 32'd0);
    rsp_valid = 1'b1; rsp_rdata = 8'h34;
    step(1);
    rsp_valid = 1'b0; rsp_rdata = 8'h00;
    check("rd_rdy_back", {31'd0, cpu_rdy}, 32'd1);
    ph2 = 1'b0;
    step(1);
    ph2 = 1'b1;
    step(1);
    check("rd_hit_din", {24'd0, cpu_din}, 32'h0000_0034);
    check("rd_hit_noreq", hs_cnt, 32'd2);
    ph2 = 1'b0;
    step(1);

    // Write then read of the same address while downstream is stalled
    req_ready = 1'b0;
    cpu_write(16'h0300, 8'h11, 1'b0);
    step(1);
    cpu_addr = 16'h0300; cpu_rwn = 1'b1; ph2 = 1'b1;
    step(1);
    check("ord_rdy", {31'd0, cpu_rdy}, 32'd0);
    step(3);
    check("ord_hold_we",   {31'd0, req_we}, 32'd1);
    check("ord_hold_addr", {16'd0, req_addr}, 32'h0000_0300);
    check("ord_hold_data", {24'd0, req_wdata}, 32'h0000_0011);
    req_ready = 1'b1;
    for (int i = 0; i < 10 && hs_cnt < 4; i++) step(1);
    check("ord_hs_cnt", hs_cnt, 32'd4);
    check("ord_first_we",  {31'd0, hs_we[2]}, 32'd1);
    check("ord_second_we", {31'd0, hs_we[3]}, 32'd0);
    check("ord_rd_addr",   {16'd0, hs_addr[3]}, 32'h0000_0300);
    rsp_valid = 1'b1; rsp_rdata = 8'h11;
    step(1);
    rsp_valid = 1'b0;
    ph2 = 1'b0;
    step(1);
    ph2 = 1'b1;
    step(1);
    check("ord_hit_din", {24'd0, cpu_din}, 32'h0000_0011);
    ph2 = 1'b0;
    step(1);

    // FIFO fill, back-pressure and overflow
    req_ready = 1'b0;
    cpu_write(16'h0400, 8'hA0, 1'b0);
    cpu_write(16'h0401, 8'hA1, 1'b0);
    check("full_rdy_cnt2", {31'd0, cpu_rdy}, 32'd1);
    cpu_write(16'h0402, 8'hA2, 1'b0);
    check("full_rdy_cnt3", {31'd0, cpu_rdy}, 32'd0);
    cpu_write(16'h0403, 8'hA3, 1'b0);
    check("full_ovf_cnt4", {31'd0, ovf}, 32'd0);
    cpu_write(16'h0404, 8'hA4, 1'b0);
    check("full_ovf_set", {31'd0, ovf}, 32'd1);
    req_ready = 1'b1;
    for (int i = 0; i < 40 && hs_cnt < 8; i++) step(1);
    step(10);
    check("full_hs_cnt", hs_cnt, 32'd8);
    check("full_e0", {hs_addr[4], hs_wdata[4], 7'd0, hs_we[4]}, 32'h0400_A001);
    check("full_e1", {hs_addr[5], hs_wdata[5], 7'd0, hs_we[5]}, 32'h0401_A101);
    check("full_e2", {hs_addr[6], hs_wdata[6], 7'd0, hs_we[6]}, 32'h0402_A201);
    check("full_e3", {hs_addr[7], hs_wdata[7], 7'd0, hs_we[7]}, 32'h0403_A301);
    check("full_rdy_back", {31'd0, cpu_rdy}, 32'd1);
    check("full_ovf_sticky", {31'd0, ovf}, 32'd1);

    // Fetch read then reset while waiting for the response
    cpu_addr = 16'h0500; cpu_rwn = 1'b1; cpu_sync = 1'b1; ph2 = 1'b1;
    step(1);
    check("rr_fetch", {31'd0, req_fetch}, 32'd1);
    check("rr_addr",  {16'd0, req_addr}, 32'h0000_0500);
    step(1);
    rst = 1'b1; ph2 = 1'b0; cpu_sync = 1'b0;
    #1;
    check("rr_din",   {24'd0, cpu_din}, 32'h0000_00FF);
    check("rr_rdy",   {31'd0, cpu_rdy}, 32'd1);
    check("rr_valid", {31'd0, req_valid}, 32'd0);
    check("rr_we",    {31'd0, req_we}, 32'd0);
    check("rr_raddr", {16'd0, req_addr}, 32'h0000_0000);
    check("rr_fetch0", {31'd0, req_fetch}, 32'd0);
    check("rr_ovf",   {31'd0, ovf}, 32'd0);
    step(2);
    rst = 1'b0;
    step(1);
    rsp_valid = 1'b1; rsp_rdata = 8'h77;
    step(1);
    rsp_valid = 1'b0;
    step(1);
    check("rr_stray_rsp_rdy", {31'd0, cpu_rdy}, 32'd1);
    check("rr_stray_rsp_din", {24'd0, cpu_din}, 32'h0000_00FF);

`ifdef M6502_BRIDGE_TRACE_EN
    // Ten bus cycles, three of them opcode fetches
    req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_write(16'h0600 + 16'(i), 8'(i), (i == 2 || i == 5 || i == 8) ? 1'b1 : 1'b0);
    end
    step(2);
    check("trace_cyc",   cyc_cnt, 32'd10);
    check("trace_fetch", fetch_cnt, 32'd3);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/m6502_bus_bridge.md
Name: m6502_bus_bridge

Overview:
- Sits directly downstream of the 6502 core's external bus (address, data-out, RWn, SYNC, PH2 phase output).
- Converts CPU bus cycles into a valid/ready request stream for on-chip memory/peripherals, and returns read data onto the CPU data-in bus.
- Buffers writes in a small FIFO. Stalls reads via RDY until the downstream response arrives.
- All logic is in the single system clock domain. PH2 is a registered, clk-synchronous signal from the core.

Parameters:
- WFIFO_DEPTH, 4, write-buffer entries; power of two, minimum 2.
- RESET_DIN, 8'hFF, value driven on cpu_din after reset and on idle cycles.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ph2  in  1  CPU PH2 phase output, synchronous to clk.
- cpu_addr  in  16  CPU address bus.
- cpu_dout  in  8  CPU write data.
- cpu_rwn  in  1  1 = read, 0 = write.
- cpu_sync  in  1  opcode-fetch cycle marker.
- cpu_din  out  8  read data to CPU.
- cpu_rdy  out  1  CPU RDY input; low stalls read cycles.
- req_valid  out  1  downstream request valid.
- req_ready  in  1  downstream accepts request.
- req_we  out  1  1 = write request.
- req_addr  out  16  request address.
- req_wdata  out  8  request write data.
- req_fetch  out  1  request is an opcode fetch (SYNC captured).
- rsp_valid  in  1  read response valid (single-cycle pulse).
- rsp_rdata  in  8  read response data.
- ovf  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset values: cpu_din=RESET_DIN, cpu_rdy=1, req_valid=0, req_we=0, req_addr=0, req_wdata=0, req_fetch=0, ovf=0; FIFO empty; hold invalid; state IDLE.
- Edge detect: ph2_q registers ph2. rise = ph2 & ~ph2_q; fall = ~ph2 & ph2_q. Address, RWn and SYNC are captured on rise.
- Write cycle (RWn=0 at rise):
  - On the following fall, push {captured addr, cpu_dout} into the FIFO.
  - If the FIFO is full at the push, drop the write and set ovf. ovf clears only on rst.
  - Writes are accepted regardless of cpu_rdy (NMOS RDY does not stall writes).
- Write drain:
  - In IDLE and DRAIN, the FIFO head drives req_valid=1, req_we=1, req_addr, req_wdata, req_fetch=0.
  - The FIFO pops on req_valid & req_ready.
  - The request fields stay stable while req_valid=1 and req_ready=0.
- Read cycle (RWn=1 at rise):
  - Hit: hold valid and hold_addr == addr. Drive cpu_din=hold_data on the next clk and clear hold. No request is issued.
  - Miss: on the next clk, cpu_rdy<=0 and latch addr/SYNC. Discard any stale hold. Go to DRAIN if the FIFO is non-empty, else go to REQ.
- State machine:
  - IDLE: on read miss, go to DRAIN or REQ as above.
  - DRAIN: pop writes until the FIFO is empty, then go to REQ. Reads never bypass older writes.
  - REQ: drive req_valid=1, req_we=0, req_addr=latched, req_fetch=latched SYNC. On req_ready, go to RESP.
  - RESP: on rsp_valid, set hold_data=rsp_rdata, hold_addr=latched, hold valid, cpu_rdy<=1, and go to IDLE. The CPU repeats the stalled cycle and hits on the hold.
- Minimum miss latency with an empty FIFO: req_valid asserts 1 clk after rise.
- FIFO back-pressure: cpu_rdy is forced low while FIFO count >= WFIFO_DEPTH-1, so at most one further in-flight write can arrive.
- Ignored events:
  - rsp_valid outside RESP.
  - ph2 edges while in DRAIN/REQ/RESP, except the write push on fall.
- Simultaneous push and pop in the same clk: count is unchanged, and both operations complete.
- Read pointer and write pointer wrap modulo WFIFO_DEPTH. Count is $clog2(WFIFO_DEPTH)+1 bits wide.
- Reset mid-transaction: everything returns to reset values immediately. Any outstanding downstream request is abandoned, and downstream must tolerate this.

Optional Feature:
- Macro: M6502_BRIDGE_TRACE_EN.
- With the macro defined, two extra outputs are added:
  - cyc_cnt (32 bits): increments on every ph2 rise.
  - fetch_cnt (32 bits): increments on ph2 rise when cpu_sync=1 and cpu_rdy=1.
  - Both reset to 0 and wrap at 2^32.
- Without the macro, the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Package m6502_bridge_pkg contains:
  - state enum {IDLE, DRAIN, REQ, RESP};
  - wfifo_entry_t struct {addr[15:0], data[7:0]};
  - DIN_IDLE constant = 8'hFF.
- Sub-module m6502_wfifo: a parameterised synchronous FIFO with push, pop, head, count, full and empty, instantiated once.

Test Plan:
- Reset: after rst, cpu_din=8'hFF, cpu_rdy=1, req_valid=0, ovf=0.
- Write at 16'h0200 with data 8'h5A: one req with we=1, addr=16'h0200, wdata=8'h5A after fall; FIFO empty afterwards.
- Read miss at 16'hFFFC with req_ready=1 and rsp 8'h34 three clks later:
  - cpu_rdy low from rise+1 until the rsp clk+1;
  - the repeated cycle returns cpu_din=8'h34 with no second request.
- Ordering: write 8'h11 to 16'h0300 with req_ready held 0, then a read of 16'h0300 → the write handshake completes before the read req asserts.
- FIFO full with WFIFO_DEPTH=4 and req_ready=0:
  - cpu_rdy drops at count 3;
  - a 5th write is dropped and ovf=1, with 4 entries retained;
  - rst mid-RESP returns all outputs to reset values.
- With M6502_BRIDGE_TRACE_EN: 10 cycles including 3 SYNC fetches → cyc_cnt=10, fetch_cnt=3.
